// File: rtl/systola_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systola_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, DONE} state_t;

  // Cycles needed after the last read for the skewed wavefront to leave the array.
  function automatic int flush_len(input int rd_lat, input int rows, input int cols);
    return rd_lat + rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_valid_skew.sv
// Diagonal skew line: bit 0 is the input itself, each higher bit is one more cycle late.
module valid_skew #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in,
  output logic [DEPTH-1:0] out
);

  generate
    if (DEPTH == 1) begin : g_passthru
      assign out = in;
    end else begin : g_chain
      logic [DEPTH-1:1] stage;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          stage <= '0;
        end else if (clr) begin
          stage <= '0;
        end else begin
          stage[1] <= in;
          for (int k = 2; k < DEPTH; k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end

      assign out = {stage, in};
    end
  endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an output-stationary PE array: clear, stream K operand
// addresses, emit skewed row/column fire enables, drain, then pulse done.
module systolic_seq_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int KW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            acc_clr,
  output logic            rd_en,
  output logic [KW-1:0]   rd_addr,
  output logic [ROWS-1:0] a_vld,
  output logic [COLS-1:0] w_vld
);

  import systola_pkg::*;

  localparam int FLUSH_LEN = flush_len(RD_LAT, ROWS, COLS);
  localparam int FW        = $clog2(RD_LAT + ROWS + COLS) + 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  state_t        state, state_next;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] cnt;
  logic [FW-1:0] flush_cnt;
  logic          abort_job;
  logic          accept;
  logic          feed_vld;

  assign abort_job = abort && (state != IDLE);
  assign accept    = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = (k_reg == '0) ? DONE : FEED;
      FEED:    if (cnt == k_reg - KW'(1)) state_next = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_job) state_next = IDLE;
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    acc_clr = (state == LOAD);
    rd_en   = (state == FEED);
  end

  // cnt sits at 0 outside FEED so rd_addr idles at 0 without extra muxing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_reg     <= '0;
      cnt       <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept) k_reg <= k_len;
      if (abort_job) begin
        cnt       <= '0;
        flush_cnt <= '0;
      end else begin
        cnt <= (state == FEED && state_next == FEED) ? cnt + KW'(1) : '0;
        if (state == FEED) begin
          flush_cnt <= FLUSH_LAST;
        end else if (state == FLUSH && flush_cnt != '0) begin
          flush_cnt <= flush_cnt - FW'(1);
        end
      end
    end
  end

  assign rd_addr = cnt;

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign feed_vld = rd_en;
    end else begin : g_lat
      logic [RD_LAT-1:0] lat_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          lat_q <= '0;
        end else if (abort_job) begin
          lat_q <= '0;
        end else begin
          lat_q[0] <= rd_en;
          for (int i = 1; i < RD_LAT; i++) begin
            lat_q[i] <= lat_q[i-1];
          end
        end
      end

      assign feed_vld = lat_q[RD_LAT-1];
    end
  endgenerate

  valid_skew #(.DEPTH(ROWS)) u_row_skew (
    .clk  (clk),
    .rstn (rstn),
    .clr  (abort_job),
    .in   (feed_vld),
    .out  (a_vld)
  );

  valid_skew #(.DEPTH(COLS)) u_col_skew (
    .clk  (clk),
    .rstn (rstn),
    .clr  (abort_job),
    .in   (feed_vld),
    .out  (w_vld)
  );

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: directed scenarios plus random
// start/abort traffic, compared cycle by cycle against a job-timeline model.
module tb_systolic_seq_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KW     = 8;
  localparam int RD_LAT = 1;
  localparam int FL     = RD_LAT + ROWS + COLS - 1;
  localparam int HIST   = 4096;

  logic            clk;
  logic            rstn;
  logic            start;
  logic            abort;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            acc_clr;
  logic            rd_en;
  logic [KW-1:0]   rd_addr;
  logic [ROWS-1:0] a_vld;
  logic [COLS-1:0] w_vld;

  systolic_seq_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .KW(KW), .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .k_len   (k_len),
    .busy    (busy),
    .done    (done),
    .acc_clr (acc_clr),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_vld   (a_vld),
    .w_vld   (w_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;

  // Job timeline model: a job accepted in cycle t0 with length jk is fully
  // described by the offset d = cyc - t0.
  bit   in_job      = 0;
  int   t0          = 0;
  int   jk          = 0;
  int   clear_cycle = -1;
  logic rd_hist [HIST];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic skew_bit(input int delay);
    int o;
    o = cyc - RD_LAT - delay;
    if (o < 0 || o <= clear_cycle) return 1'b0;
    return rd_hist[o];
  endfunction

  task automatic apply_stimulus(input logic s, input logic a, input logic [KW-1:0] k);
    int d, end_d;
    logic e_busy, e_done, e_clr, e_rd;
    logic [KW-1:0] e_addr;
    logic [ROWS-1:0] e_a;
    logic [COLS-1:0] e_w;
    start = s;
    abort = a;
    k_len = k;
    @(negedge clk);
    d = 0; end_d = 0;
    e_busy = 0; e_done = 0; e_clr = 0; e_rd = 0; e_addr = '0;
    if (in_job) begin
      d      = cyc - t0;
      end_d  = (jk == 0) ? 2 : jk + FL + 2;
      e_busy = (d >= 1);
      e_clr  = (d == 1);
      e_rd   = (jk > 0) && (d >= 2) && (d <= jk + 1);
      e_addr = e_rd ? KW'(d - 2) : '0;
      e_done = (d == end_d);
    end
    rd_hist[cyc] = e_rd;
    for (int i = 0; i < ROWS; i++) e_a[i] = skew_bit(i);
    for (int j = 0; j < COLS; j++) e_w[j] = skew_bit(j);
    check_output("busy",    32'(busy),    32'(e_busy));
    check_output("done",    32'(done),    32'(e_done));
    check_output("acc_clr", 32'(acc_clr), 32'(e_clr));
    check_output("rd_en",   32'(rd_en),   32'(e_rd));
    check_output("rd_addr", 32'(rd_addr), 32'(e_addr));
    check_output("a_vld",   32'(a_vld),   32'(e_a));
    check_output("w_vld",   32'(w_vld),   32'(e_w));
    if (in_job) begin
      if (a) begin
        in_job      = 0;
        clear_cycle = cyc;
      end else if (d == end_d) begin
        in_job = 0;
      end
    end else if (s && !a) begin
      in_job = 1;
      t0     = cyc;
      jk     = int'(k);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, KW'($urandom));
  endtask

  task automatic async_reset();
    start = 1'b0;
    abort = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_output("rst_busy",  32'(busy),    32'd0);
    check_output("rst_done",  32'(done),    32'd0);
    check_output("rst_clr",   32'(acc_clr), 32'd0);
    check_output("rst_rd_en", 32'(rd_en),   32'd0);
    check_output("rst_addr",  32'(rd_addr), 32'd0);
    check_output("rst_a_vld", 32'(a_vld),   32'd0);
    check_output("rst_w_vld", 32'(w_vld),   32'd0);
    in_job        = 0;
    rd_hist[cyc]  = 1'b0;
    clear_cycle   = cyc;
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    k_len = '0;
    @(posedge clk);
    #1;
    check_output("reset_busy",  32'(busy),    32'd0);
    check_output("reset_rd_en", 32'(rd_en),   32'd0);
    check_output("reset_a_vld", 32'(a_vld),   32'd0);
    check_output("reset_w_vld", 32'(w_vld),   32'd0);
    check_output("reset_addr",  32'(rd_addr), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // nominal K=3 job
    apply_stimulus(1'b1, 1'b0, 8'd3);
    idle_cycles(15);

    // empty job
    apply_stimulus(1'b1, 1'b0, 8'd0);
    idle_cycles(4);

    // start re-pulsed during FEED with another length
    apply_stimulus(1'b1, 1'b0, 8'd3);
    idle_cycles(2);
    apply_stimulus(1'b1, 1'b0, 8'd7);
    idle_cycles(14);

    // abort in the second FEED cycle, then a clean job
    apply_stimulus(1'b1, 1'b0, 8'd5);
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b1, 8'd5);
    idle_cycles(3);
    apply_stimulus(1'b1, 1'b0, 8'd3);
    idle_cycles(15);

    // abort wins over start in IDLE
    apply_stimulus(1'b1, 1'b1, 8'd4);
    idle_cycles(3);

    // asynchronous reset in the middle of FLUSH
    apply_stimulus(1'b1, 1'b0, 8'd2);
    idle_cycles(6);
    async_reset();
    idle_cycles(4);

    // maximum length job, start held high through DONE
    apply_stimulus(1'b1, 1'b0, 8'd255);
    for (int i = 0; i < 268; i++) apply_stimulus(1'b1, 1'b0, 8'd2);
    idle_cycles(16);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 29) == 0),
                     KW'($urandom_range(0, 10)));
    end
    idle_cycles(20);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an output-stationary ROWS x COLS PE array.
- On a start handshake it clears the PE accumulators and streams K operand addresses to the activation and weight buffers.
- Generates the diagonally skewed fire/valid enables for each array row and column, then waits for the wavefront to drain and pulses done.
- Sits between the host/command logic and the PE array plus its operand buffers.

Parameters:
- ROWS, 4, number of PE rows (activation edge inputs), >=1
- COLS, 4, number of PE columns (weight edge inputs), >=1
- KW, 8, width of k_len and the read address
- RD_LAT, 1, operand buffer read latency in cycles, >=0

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  request a new accumulation job; sampled only in IDLE
- abort  input  1  synchronous cancel of the current job
- k_len  input  KW  accumulation length K; captured when start is accepted
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; accumulators final and readable
- acc_clr  output  1  one-cycle pulse; clears all PE accumulators
- rd_en  output  1  operand buffer read enable (A and W share it)
- rd_addr  output  KW  operand buffer read address
- a_vld  output  ROWS  row-edge fire; bit i = base valid delayed i cycles
- w_vld  output  COLS  column-edge fire; bit j = base valid delayed j cycles

Behaviour:
- Reset (rstn low, asynchronous): state = IDLE. busy, done, acc_clr, rd_en = 0. rd_addr = 0. a_vld and w_vld = all 0. All delay and skew registers = 0. Counters = 0.
- FSM states: IDLE -> LOAD -> FEED -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start=1 and abort=0: capture k_len into k_reg, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): acc_clr=1.
  - k_reg=0: go to DONE (no reads, no valids).
  - Otherwise go to FEED with cnt=0.
- FEED (k_reg cycles):
  - rd_en=1, rd_addr=cnt; cnt increments each cycle.
  - When cnt = k_reg-1, go to FLUSH.
- FLUSH: fixed length RD_LAT+ROWS+COLS-1 cycles, counted with a down-counter; then go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Base valid: feed_vld = rd_en delayed exactly RD_LAT cycles (RD_LAT=0 means combinational equality). Every delay stage resets to 0.
- Skew outputs:
  - a_vld[0] = feed_vld; a_vld[i] = a_vld[i-1] delayed one cycle.
  - w_vld is built the same way, COLS deep.
  - Both outputs are registered except bit 0.
- All outputs are Moore outputs of the state and counters, so no combinational path from start or abort.
- start while busy: ignored, with no effect on k_reg.
- abort=1 in any non-IDLE state: the next cycle is IDLE. The same edge clears the counters and every delay/skew stage to 0. No done is issued. abort in IDLE is a no-op and wins over a simultaneous start.
- k_len changes after acceptance have no effect.
- k_reg = 2^KW-1: rd_addr runs 0..2^KW-2 and never wraps.
- Width rules:
  - cnt and rd_addr are KW bits.
  - The flush counter is clog2(RD_LAT+ROWS+COLS)+1 bits.
- Back-to-back jobs: start held high through DONE is accepted in the first IDLE cycle after DONE, so there is at least one IDLE cycle between jobs.

Decomposition:
- Shared package systola_pkg: FSM state enum (IDLE, LOAD, FEED, FLUSH, DONE) and the flush-length constant function of RD_LAT/ROWS/COLS.
- One sub-module, valid_skew:
  - Parameter DEPTH; inputs clk, rstn, clr, in; output vector out[DEPTH].
  - out[0] = in; out[k] = out[k-1] delayed one cycle.
  - clr forces all stages to 0.
  - Instantiated twice (ROWS and COLS). The RD_LAT delay is a small shift register in the top.

Test Plan:
- Nominal job (ROWS=COLS=4, RD_LAT=1, k_len=3, start pulsed in cycle 0) -> acc_clr in cycle 1; rd_en cycles 2-4 with rd_addr 0,1,2; a_vld[0] cycles 3-5; a_vld[3] and w_vld[3] cycles 6-8; done only in cycle 13; busy high cycles 1-13.
- k_len=0 -> acc_clr in cycle 1, done in cycle 2; rd_en, a_vld and w_vld never assert.
- start re-pulsed during FEED with a different k_len -> ignored; exactly 3 reads, done timing unchanged.
- abort asserted in the 2nd FEED cycle -> busy=0 next cycle; rd_en, a_vld and w_vld all 0 from that cycle; no done. A new start then runs cleanly from rd_addr 0.
- rstn pulled low mid-FLUSH (asynchronous, between edges) -> all outputs 0 immediately; after release, IDLE with no spurious done.
- k_len=255 (KW=8) -> 255 reads with addresses 0..254, no wrap; done exactly 1+255+8+1 cycles after acceptance.
